// File: rtl/clock_alarm_pkg.sv
// Shared types, widths and limits for the clock/alarm core and its hour:minute counters.
// Includes the hour:minute wrap helpers used by both the counters and the alarm compare.
package clock_alarm_pkg;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int RCNT_W   = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  mins;
    } hm_t;

    function automatic hm_t hm_inc(input hm_t v);
        hm_t r;
        r = v;
        if (v.mins == MIN_W'(MAX_MIN)) begin
            r.mins  = '0;
            r.hours = (v.hours == HOUR_W'(MAX_HOUR)) ? '0 : v.hours + HOUR_W'(1);
        end else begin
            r.mins = v.mins + MIN_W'(1);
        end
        return r;
    endfunction

    function automatic hm_t hm_dec(input hm_t v);
        hm_t r;
        r = v;
        if (v.mins == '0) begin
            r.mins  = MIN_W'(MAX_MIN);
            r.hours = (v.hours == '0) ? HOUR_W'(MAX_HOUR) : v.hours - HOUR_W'(1);
        end else begin
            r.mins = v.mins - MIN_W'(1);
        end
        return r;
    endfunction
endpackage

// File: rtl/clock_alarm_core_hm_counter.sv
// Hour:minute register with +1/-1 steps and a +1 carry input, wrapping 23:59 <-> 00:00.
// Simultaneous up and down requests cancel.
import clock_alarm_pkg::*;

module hm_counter (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              carry_i,
    output logic [HOUR_W-1:0] hour_o,
    output logic [MIN_W-1:0]  min_o
);
    hm_t  hm_q, hm_d;
    logic up;

    assign up = inc_i | carry_i;

    always_comb begin
        hm_d = hm_q;
        if (up && !dec_i) begin
            hm_d = hm_inc(hm_q);
        end else if (dec_i && !up) begin
            hm_d = hm_dec(hm_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hm_q <= '0;
        end else begin
            hm_q <= hm_d;
        end
    end

    assign hour_o = hm_q.hours;
    assign min_o  = hm_q.mins;
endmodule

// File: rtl/clock_alarm_core.sv
// Clock/alarm back end: prescaler, seconds, edge-detected adjust steps and ring FSM.
// Define CLOCK_ALARM_SNOOZE_EN to add the snooze input and SNOOZE state.
//
//  state     | meaning
//  ST_IDLE   | not sounding, waiting for the alarm minute
//  ST_RING   | sounding; counts minute rollovers towards auto-stop
//  ST_SNOOZE | silenced by snooze; counts minute rollovers until re-ring
import clock_alarm_pkg::*;

module clock_alarm_core #(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int RING_MIN      = 1
`ifdef CLOCK_ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_MIN    = 9
`endif
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              c_plus_i,
    input  logic              c_minus_i,
    input  logic              a_plus_i,
    input  logic              a_minus_i,
    input  logic              alarm_on_i,
`ifdef CLOCK_ALARM_SNOOZE_EN
    input  logic              snooze_i,
`endif
    output logic [HOUR_W-1:0] clk_hour_o,
    output logic [MIN_W-1:0]  clk_min_o,
    output logic [SEC_W-1:0]  clk_sec_o,
    output logic [HOUR_W-1:0] al_hour_o,
    output logic [MIN_W-1:0]  al_min_o,
    output logic              ringing_o
);
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [3:0]         adj_q, adj_prev_q, adj_edge;
    logic               c_inc, c_dec, c_step, a_inc, a_dec, al_edge;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               tick, sec_carry, alarm_hit;
    hm_t                clk_cur, al_cur;
    state_e             state_q;
    logic [RCNT_W-1:0]  ring_cnt_q, ring_cnt_nxt;
    logic               ringing_q;

    // Adjust levels: {c_plus, c_minus, a_plus, a_minus}
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            adj_q      <= '0;
            adj_prev_q <= '0;
        end else begin
            adj_q      <= {c_plus_i, c_minus_i, a_plus_i, a_minus_i};
            adj_prev_q <= adj_q;
        end
    end

    assign adj_edge = adj_q & ~adj_prev_q;
    assign c_inc    = adj_edge[3] & ~adj_edge[2];
    assign c_dec    = adj_edge[2] & ~adj_edge[3];
    assign c_step   = c_inc | c_dec;
    assign a_inc    = adj_edge[1] & ~adj_edge[0];
    assign a_dec    = adj_edge[0] & ~adj_edge[1];
    assign al_edge  = adj_edge[1] | adj_edge[0];

`ifdef CLOCK_ALARM_SNOOZE_EN
    logic snz_q, snz_prev_q, snz_edge;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snz_q      <= 1'b0;
            snz_prev_q <= 1'b0;
        end else begin
            snz_q      <= snooze_i;
            snz_prev_q <= snz_q;
        end
    end

    assign snz_edge = snz_q & ~snz_prev_q;
`endif

    assign tick      = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
    // A clock step restarts the second, so a coincident tick is dropped.
    assign sec_carry = tick & ~c_step & (sec_q == SEC_W'(MAX_SEC));

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        sec_d   = sec_q;
        if (c_step) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            sec_d   = sec_carry ? '0 : sec_q + SEC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    hm_counter u_clk_hm (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (c_inc),
        .dec_i   (c_dec),
        .carry_i (sec_carry),
        .hour_o  (clk_hour_o),
        .min_o   (clk_min_o)
    );

    hm_counter u_al_hm (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (a_inc),
        .dec_i   (a_dec),
        .carry_i (1'b0),
        .hour_o  (al_hour_o),
        .min_o   (al_min_o)
    );

    assign clk_cur = {clk_hour_o, clk_min_o};
    assign al_cur  = {al_hour_o, al_min_o};

    // Only a seconds rollover into the alarm minute triggers; steps never do.
    assign alarm_hit    = sec_carry & alarm_on_i & (hm_inc(clk_cur) == al_cur);
    assign ring_cnt_nxt = ring_cnt_q + RCNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alarm_hit) begin
                        state_q    <= ST_RING;
                        ring_cnt_q <= '0;
                        ringing_q  <= 1'b1;
                    end
                end
                ST_RING: begin
                    if (!alarm_on_i || al_edge) begin
                        state_q   <= ST_IDLE;
                        ringing_q <= 1'b0;
`ifdef CLOCK_ALARM_SNOOZE_EN
                    end else if (snz_edge) begin
                        state_q    <= ST_SNOOZE;
                        ring_cnt_q <= '0;
                        ringing_q  <= 1'b0;
`endif
                    end else if (sec_carry) begin
                        ring_cnt_q <= ring_cnt_nxt;
                        if (ring_cnt_nxt == RCNT_W'(RING_MIN)) begin
                            state_q   <= ST_IDLE;
                            ringing_q <= 1'b0;
                        end
                    end
                end
`ifdef CLOCK_ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (!alarm_on_i || al_edge) begin
                        state_q <= ST_IDLE;
                    end else if (sec_carry) begin
                        ring_cnt_q <= ring_cnt_nxt;
                        if (ring_cnt_nxt == RCNT_W'(SNOOZE_MIN)) begin
                            state_q    <= ST_RING;
                            ring_cnt_q <= '0;
                            ringing_q  <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q   <= ST_IDLE;
                    ringing_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk_sec_o = sec_q;
    assign ringing_o = ringing_q;
endmodule
